// File: rtl/sramlike_arbiter.sv
// Two-into-one sram-like bus arbiter: instruction and data masters share one downstream port.
// An owner FIFO remembers who issued each accepted request so responses return in order to the right side.
module sramlike_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

    logic [MAX_OUTSTANDING-1:0] owner_fifo_r;
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic [3:0]                 starve_cnt_r;

    logic any_req_s;
    logic full_s;
    logic sel_data_s;
    logic push_s;
    logic pop_s;
    logic inst_hs_s;
    logic data_hs_s;
    logic head_owner_s;
    logic err_spurious_s;

    // Pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    assign any_req_s      = inst_req | data_req;
    assign full_s         = (count_r == CNT_MAX);
    assign err_spurious_s = mem_data_ok & (count_r == CNT_ZERO);
    assign pop_s          = rst & mem_data_ok & ~err_spurious_s;

    // A pop in the same cycle frees a slot, so a full FIFO may still grant.
    assign mem_req    = any_req_s & (~full_s | pop_s);
    assign sel_data_s = data_req & ~(inst_req & (starve_cnt_r == STARVE_MAX));

    assign push_s    = rst & mem_req & mem_addr_ok;
    assign inst_hs_s = push_s & ~sel_data_s;
    assign data_hs_s = push_s & sel_data_s;

    assign inst_addr_ok = inst_hs_s;
    assign data_addr_ok = data_hs_s;

    assign head_owner_s = owner_fifo_r[rd_ptr_r];
    assign inst_data_ok = pop_s & ~head_owner_s;
    assign data_data_ok = pop_s & head_owner_s;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // Downstream request fields follow the granted side; inst fields when idle.
    always_comb begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
        if (mem_req & sel_data_s) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    // Owner FIFO storage and write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_fifo_r <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_r     <= PTR_ZERO;
        end else if (push_s) begin
            owner_fifo_r[wr_ptr_r] <= sel_data_s;
            wr_ptr_r               <= ptr_next(wr_ptr_r);
        end
    end

    // Read pointer advances on every routed response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= PTR_ZERO;
        end else if (pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
        end
    end

    // Outstanding count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Counts data grants that jumped ahead of a waiting inst request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 4'd0;
        end else if (!inst_req || inst_hs_s) begin
            starve_cnt_r <= 4'd0;
        end else if (data_hs_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: directed vector table, a starvation-pattern sequence,
// then random traffic checked cycle by cycle against a queue-based reference model.
module tb_sramlike_arbiter;
    localparam int MAX = 2;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;

    always #5 clk = ~clk;

    sramlike_arbiter #(.MAX_OUTSTANDING(MAX), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    typedef struct {
        logic rst, ir, iw, dr, dw, maok, mdok;
        logic [1:0] isz, dsz;
        logic [31:0] iaddr, iwdata, daddr, dwdata, mrdata;
    } stim_t;

    typedef struct {
        stim_t s;
        logic [37:0] exp_key;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int owner_q[$];
    int streak = 0;
    vec_t tbl[$];

    function automatic stim_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                                 logic [31:0] da, logic [31:0] dwd, logic maok, logic mdok,
                                 logic [31:0] rd);
        stim_t s;
        s.rst = r; s.ir = ir; s.iw = 1'b0; s.isz = 2'd2; s.iaddr = ia; s.iwdata = 32'h0;
        s.dr = dr; s.dw = dw; s.dsz = 2'd2; s.daddr = da; s.dwdata = dwd;
        s.maok = maok; s.mdok = mdok; s.mrdata = rd;
        return s;
    endfunction

    function automatic vec_t mv(stim_t s, logic req, logic [31:0] addr,
                                logic iaok, logic daok, logic idok, logic ddok);
        vec_t v;
        v.s = s;
        v.exp_key = {req, addr, iaok, daok, idok, ddok};
        return v;
    endfunction

    // One cycle: drive, check everything against the reference model, advance the model.
    task automatic step(input stim_t s, input string name, output logic [37:0] key);
        logic pop, mreq, pick, use_d, hs;
        logic [135:0] expv, actv;
        rst = s.rst; inst_req = s.ir; inst_wr = s.iw; inst_size = s.isz;
        inst_addr = s.iaddr; inst_wdata = s.iwdata;
        data_req = s.dr; data_wr = s.dw; data_size = s.dsz;
        data_addr = s.daddr; data_wdata = s.dwdata;
        mem_addr_ok = s.maok; mem_data_ok = s.mdok; mem_rdata = s.mrdata;
        if (!s.rst) begin
            owner_q.delete();
            streak = 0;
        end
        #4;
        pop   = s.rst && s.mdok && (owner_q.size() > 0);
        mreq  = (s.ir || s.dr) && ((owner_q.size() < MAX) || pop);
        pick  = s.dr && !(s.ir && streak == LIM);
        use_d = mreq && pick;
        hs    = s.rst && mreq && s.maok;
        expv = {mreq, use_d ? s.dw : s.iw, use_d ? s.dsz : s.isz,
                use_d ? s.daddr : s.iaddr, use_d ? s.dwdata : s.iwdata,
                hs && !pick, hs && pick,
                pop && owner_q[0] == 0, pop && owner_q[0] == 1,
                s.mrdata, s.mrdata};
        actv = {mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
                inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                inst_rdata, data_rdata};
        key = {mem_req, mem_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
        n_vec++;
        if (actv !== expv) begin
            n_bad++;
            $display("FAIL model %s: got %h expected %h", name, actv, expv);
        end
        @(posedge clk);
        if (s.rst) begin
            if (pop) void'(owner_q.pop_front());
            if (hs) owner_q.push_back(pick ? 1 : 0);
            if (!s.ir || (hs && !pick)) streak = 0;
            else if (hs && pick && streak < LIM) streak++;
        end
        #1;
    endtask

    initial begin
        stim_t s;
        logic [37:0] key;
        logic [1:0] exp_ok;

        // reset behaviour, then the directed scenarios
        tbl.push_back(mv(mk(1'b0, 1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0), 1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'hBFC00000, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C010001), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00004, 1'b1, 1'b1, 32'h80000010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0), 1'b1, 32'h80000010, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80000020, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'h80000020, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'hBFC00008, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22222222), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'hBFC00010, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00014, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'hBFC00014, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00018, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b0, 32'hBFC00018, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00018, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0), 1'b1, 32'hBFC00018, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'hBFC00020, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80000030, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'h80000030, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b0, 1'b1, 32'hBFC00024, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0), 1'b1, 32'hBFC00024, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b1, 32'hBFC00028, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0), 1'b1, 32'hBFC00028, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mv(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));

        s = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0; inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0;
        inst_wdata = 32'h0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'h0; data_wdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_rdata = 32'h0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, $sformatf("table%0d", i), key);
            n_vec++;
            if (key !== tbl[i].exp_key) begin
                n_bad++;
                $display("FAIL table%0d: got %h expected %h", i, key, tbl[i].exp_key);
            end
        end

        // both sides held: four data grants then one inst grant, repeating
        for (int k = 0; k < 15; k++) begin
            s = mk(1'b1, 1'b1, 32'hBFC10000 + 32'(k), 1'b1, 1'b0, 32'h80010000 + 32'(k), 32'h0,
                   1'b1, (k > 0) ? 1'b1 : 1'b0, 32'(k));
            step(s, $sformatf("starve%0d", k), key);
            exp_ok = (k % 5 == 4) ? 2'b10 : 2'b01;
            n_vec++;
            if (key[3:2] !== exp_ok) begin
                n_bad++;
                $display("FAIL starve%0d: addr_ok inst/data got %b expected %b", k, key[3:2], exp_ok);
            end
        end

        // random traffic with occasional reset
        for (int k = 0; k < 500; k++) begin
            s.rst    = ($urandom_range(0, 59) != 0);
            s.ir     = 1'($urandom_range(0, 1));
            s.iw     = 1'($urandom_range(0, 1));
            s.isz    = 2'($urandom_range(0, 3));
            s.iaddr  = $urandom;
            s.iwdata = $urandom;
            s.dr     = 1'($urandom_range(0, 1));
            s.dw     = 1'($urandom_range(0, 1));
            s.dsz    = 2'($urandom_range(0, 3));
            s.daddr  = $urandom;
            s.dwdata = $urandom;
            s.maok   = ($urandom_range(0, 3) != 0);
            s.mdok   = ($urandom_range(0, 2) == 0);
            s.mrdata = $urandom;
            step(s, $sformatf("rand%0d", k), key);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
